// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl
//   Memory-mapped timer plus two-source interrupt controller for the
//   single-cycle CPU. It owns a four-word register window at BASE_ADDR and
//   drives the CPU's single IRQ line through a request/ack/return handshake
//   that is keyed to the kernel-mode PC bit.
//
//   Register map (word offsets from BASE_ADDR):
//     +0x0 TH    reload value
//     +0x4 TL    counter
//     +0x8 TCON  [0] run, [1] timer IRQ mask, [2] uart IRQ mask
//     +0xC ISR   [0] timer pending, [1] uart pending (write-1-to-clear)
//
// Ports
//   sysclk        system clock, all state updates on the rising edge
//   reset         synchronous active-high reset
//   rd, wr        peripheral read / write strobes
//   addr          byte address
//   wdata         write data
//   rdata         combinational read data (0 when not a valid read)
//   uart_rx_done  one-cycle pulse when a UART byte has arrived
//   in_kernel     PC[31], high while the CPU runs the handler
//   irq_ack       one-cycle pulse when the CPU takes the interrupt
//   irq           registered interrupt request
//   irq_cause     0 = timer, 1 = uart; frozen while the request is raised

module irq_timer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          NUM_SRC   = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx_done,
  input  logic        in_kernel,
  input  logic        irq_ack,
  output logic        irq,
  output logic [1:0]  irq_cause
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [31:0]        th;
  logic [31:0]        tl;
  logic [2:0]         tcon;
  logic [NUM_SRC-1:0] isr;

  state_t             state;
  logic               in_kernel_q;

  logic               in_window;
  logic               wr_th;
  logic               wr_tl;
  logic               wr_tcon;
  logic               wr_isr;
  logic               overflow;
  logic [NUM_SRC-1:0] isr_set;
  logic [NUM_SRC-1:0] isr_clr;
  logic               timer_req;
  logic               uart_req;
  logic               req;

  // Only aligned words inside the 16-byte window are decoded; anything else
  // reads as zero and is never written.
  assign in_window = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);

  assign wr_th   = wr && in_window && (addr[3:2] == 2'd0);
  assign wr_tl   = wr && in_window && (addr[3:2] == 2'd1);
  assign wr_tcon = wr && in_window && (addr[3:2] == 2'd2);
  assign wr_isr  = wr && in_window && (addr[3:2] == 2'd3);

  assign overflow  = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign isr_set   = {uart_rx_done, overflow};
  assign isr_clr   = wr_isr ? wdata[NUM_SRC-1:0] : '0;

  assign timer_req = isr[0] && tcon[1];
  assign uart_req  = isr[1] && tcon[2];
  assign req       = timer_req || uart_req;

  // Zero-latency read mux; a deselected or misaligned access returns zero.
  always_comb begin
    rdata = 32'h0;
    if (rd && in_window) begin
      case (addr[3:2])
        2'd0:    rdata = th;
        2'd1:    rdata = tl;
        2'd2:    rdata = {29'h0, tcon};
        default: rdata = {{(32 - NUM_SRC){1'b0}}, isr};
      endcase
    end
  end

  // Register file and timer. A software TL write overrides the increment or
  // reload in the same cycle; reload uses the TH value held before this edge.
  // Hardware set is OR-ed in after the W1C mask so a colliding event survives.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      th   <= 32'h0;
      tl   <= 32'h0;
      tcon <= 3'h0;
      isr  <= '0;
    end else begin
      if (wr_th) begin
        th <= wdata;
      end
      if (wr_tl) begin
        tl <= wdata;
      end else if (tcon[0]) begin
        tl <= overflow ? th : tl + 32'd1;
      end
      if (wr_tcon) begin
        tcon <= wdata[2:0];
      end
      isr <= (isr & ~isr_clr) | isr_set;
    end
  end

  // Interrupt handshake. The return from the handler is recognised as a
  // falling edge on in_kernel, so in_kernel is delayed by one cycle here.
  // An ack in ASSERT beats a request that drops in the same cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      irq         <= 1'b0;
      irq_cause   <= 2'd0;
      in_kernel_q <= 1'b0;
    end else begin
      in_kernel_q <= in_kernel;
      case (state)
        ST_IDLE: begin
          if (req && !in_kernel) begin
            state     <= ST_ASSERT;
            irq       <= 1'b1;
            irq_cause <= timer_req ? 2'd0 : 2'd1;
          end
        end
        ST_ASSERT: begin
          if (irq_ack) begin
            state <= ST_SERVICE;
            irq   <= 1'b0;
          end else if (!req) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (in_kernel_q && !in_kernel) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// tb_irq_timer_ctrl
//   Self-checking bench for irq_timer_ctrl: directed scenarios with constant
//   expectations, then randomized traffic against a behavioural model.

module tb_irq_timer_ctrl;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        uart_rx_done;
  logic        in_kernel;
  logic        irq_ack;
  logic        irq;
  logic [1:0]  irq_cause;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_rdata;

  // Behavioural model state
  logic [31:0] m_th;
  logic [31:0] m_tl;
  logic [2:0]  m_tcon;
  logic [1:0]  m_isr;
  logic        m_irq;
  logic        m_in_handler;
  logic        m_kernel_prev;
  logic [1:0]  m_cause;

  irq_timer_ctrl dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .rd           (rd),
    .wr           (wr),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .uart_rx_done (uart_rx_done),
    .in_kernel    (in_kernel),
    .irq_ack      (irq_ack),
    .irq          (irq),
    .irq_cause    (irq_cause)
  );

  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a >= BASE && a <= BASE + 32'hC && a[1:0] == 2'b00) begin
      if (a == BASE)              v = m_th;
      else if (a == BASE + 32'h4) v = m_tl;
      else if (a == BASE + 32'h8) v = {29'h0, m_tcon};
      else                        v = {30'h0, m_isr};
    end
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    logic        hit;
    logic [31:0] off;
    logic        wants_timer;
    logic        wants_uart;
    logic        timer_wraps;
    logic [1:0]  cleared;
    if (reset) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_isr = 0;
      m_irq = 0; m_in_handler = 0; m_kernel_prev = 0; m_cause = 0;
      return;
    end
    hit         = wr && (addr >= BASE) && (addr <= BASE + 32'hC) && (addr[1:0] == 2'b00);
    off         = addr - BASE;
    wants_timer = m_isr[0] && m_tcon[1];
    wants_uart  = m_isr[1] && m_tcon[2];
    timer_wraps = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);

    // Interrupt side, judged on the register values from before this edge.
    if (m_irq) begin
      if (irq_ack) begin
        m_irq = 0; m_in_handler = 1;
      end else if (!(wants_timer || wants_uart)) begin
        m_irq = 0;
      end
    end else if (m_in_handler) begin
      if (m_kernel_prev == 1 && in_kernel == 0) m_in_handler = 0;
    end else if ((wants_timer || wants_uart) && !in_kernel) begin
      m_irq   = 1;
      m_cause = wants_timer ? 2'd0 : 2'd1;
    end
    m_kernel_prev = in_kernel;

    // Register side.
    cleared = (hit && off == 12) ? wdata[1:0] : 2'b00;
    if (hit && off == 4)   m_tl = wdata;
    else if (timer_wraps)  m_tl = m_th;
    else if (m_tcon[0])    m_tl = m_tl + 1;
    if (hit && off == 0)   m_th = wdata;
    if (hit && off == 8)   m_tcon = wdata[2:0];
    m_isr = (m_isr & ~cleared) | {uart_rx_done, timer_wraps};
  endtask

  // One full clock: apply inputs, check read data, clock, check outputs.
  task automatic applyStimulus(input logic r_rst, input logic r_rd, input logic r_wr,
                               input logic [31:0] r_addr, input logic [31:0] r_wdata,
                               input logic r_uart, input logic r_k, input logic r_ack);
    reset = r_rst; rd = r_rd; wr = r_wr; addr = r_addr; wdata = r_wdata;
    uart_rx_done = r_uart; in_kernel = r_k; irq_ack = r_ack;
    #1;
    last_rdata = rdata;
    checkOutput("rdata", rdata, r_rd ? modelRead(r_addr) : 32'h0);
    @(posedge sysclk);
    modelStep();
    #1;
    checkOutput("irq", {31'h0, irq}, {31'h0, m_irq});
    checkOutput("irq_cause", {30'h0, irq_cause}, {30'h0, m_cause});
  endtask

  task automatic cyc(input logic k, input logic u = 1'b0, input logic ack = 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, u, k, ack);
  endtask

  task automatic wrReg(input logic [3:0] off, input logic [31:0] d,
                       input logic k = 1'b0, input logic u = 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE | {28'h0, off}, d, u, k, 1'b0);
  endtask

  task automatic rdReg(input logic [3:0] off, input logic k = 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE | {28'h0, off}, 32'h0, 1'b0, k, 1'b0);
  endtask

  initial begin
    logic        k;
    logic [31:0] a;
    logic [31:0] d;
    int          sel;

    reset = 1'b1; rd = 0; wr = 0; addr = 0; wdata = 0;
    uart_rx_done = 0; in_kernel = 0; irq_ack = 0;
    @(posedge sysclk);
    #1;

    // Reset values
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rdReg(4'(i * 4));
      checkOutput("t1_reg_zero", last_rdata, 32'h0);
    end
    checkOutput("t1_irq", {31'h0, irq}, 32'h0);

    // Window boundaries
    wrReg(4'h0, 32'h12345678);
    rdReg(4'h1);
    checkOutput("unaligned_rd", last_rdata, 32'h0);
    applyStimulus(0, 1, 0, BASE + 32'h10, 0, 0, 0, 0);
    checkOutput("outside_rd", last_rdata, 32'h0);
    applyStimulus(0, 0, 1, BASE + 32'h2, 32'hFFFF_FFFF, 0, 0, 0);
    rdReg(4'h0);
    checkOutput("unaligned_wr", last_rdata, 32'h12345678);

    // Timer overflow and reload
    wrReg(4'h0, 32'hFFFF_FFF0);
    wrReg(4'h4, 32'hFFFF_FFFE);
    wrReg(4'h8, 32'h3);
    cyc(0);
    cyc(0);
    rdReg(4'h4);
    checkOutput("t2_reload", last_rdata, 32'hFFFF_FFF0);
    checkOutput("t2_irq", {31'h0, irq}, 32'h1);
    checkOutput("t2_cause", {30'h0, irq_cause}, 32'h0);
    rdReg(4'hC);
    checkOutput("t2_isr", last_rdata, 32'h1);

    // Ack, clear, return
    cyc(1, 0, 1);
    checkOutput("t3_ack_irq", {31'h0, irq}, 32'h0);
    wrReg(4'h8, 32'h2, 1);
    wrReg(4'hC, 32'h1, 1);
    cyc(0);
    cyc(0);
    checkOutput("t3_idle_irq", {31'h0, irq}, 32'h0);
    rdReg(4'hC);
    checkOutput("t3_isr", last_rdata, 32'h0);

    // Simultaneous sources, timer wins, uart follows after return
    wrReg(4'h4, 32'hFFFF_FFFF);
    wrReg(4'h8, 32'h7);
    cyc(0, 1);
    wrReg(4'h8, 32'h6);
    checkOutput("t4_irq", {31'h0, irq}, 32'h1);
    checkOutput("t4_cause", {30'h0, irq_cause}, 32'h0);
    rdReg(4'hC);
    checkOutput("t4_isr", last_rdata, 32'h3);
    cyc(1, 0, 1);
    wrReg(4'hC, 32'h1, 1);
    cyc(0);
    cyc(0);
    checkOutput("t4_reirq", {31'h0, irq}, 32'h1);
    checkOutput("t4_recause", {30'h0, irq_cause}, 32'h1);

    // Set beats W1C, kernel mode holds irq low
    cyc(1, 0, 1);
    applyStimulus(0, 0, 1, BASE + 32'hC, 32'h2, 1, 1, 0);
    rdReg(4'hC, 1);
    checkOutput("t5_isr_kept", last_rdata, 32'h2);
    checkOutput("t5_irq", {31'h0, irq}, 32'h0);
    wrReg(4'hC, 32'h2, 1);
    rdReg(4'hC, 1);
    checkOutput("t5_isr_clr", last_rdata, 32'h0);
    cyc(0);
    cyc(0);
    checkOutput("t5_idle_irq", {31'h0, irq}, 32'h0);

    // Request withdrawn before ack, then reset during service
    wrReg(4'h4, 32'hFFFF_FFFF);
    wrReg(4'h8, 32'h3);
    cyc(0);
    cyc(0);
    checkOutput("t6_irq", {31'h0, irq}, 32'h1);
    wrReg(4'h8, 32'h0);
    cyc(0);
    checkOutput("t6_withdrawn", {31'h0, irq}, 32'h0);
    wrReg(4'h8, 32'h2);
    cyc(0);
    checkOutput("t6_reassert", {31'h0, irq}, 32'h1);
    cyc(1, 0, 1);
    applyStimulus(1, 0, 1, BASE, 32'hDEAD_BEEF, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      rdReg(4'(i * 4), 1);
      checkOutput("t6_reg_zero", last_rdata, 32'h0);
    end
    checkOutput("t6_irq_zero", {31'h0, irq}, 32'h0);
    cyc(0);
    cyc(0);

    // Randomized traffic against the model
    k = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + 32'(4 * (sel % 4));
      else if (sel == 8) a = BASE + 32'($urandom_range(0, 19));
      else               a = $urandom;
      d = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if ($urandom_range(0, 9) == 0) k = ~k;
      applyStimulus($urandom_range(0, 299) == 0,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0,
                    a, d,
                    $urandom_range(0, 15) == 0,
                    k,
                    irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
